madd_seq_approx: RTL and testbench

- Parametrised, sequential successor to the fixed-width combinational approximate multiply-add blocks; computes a*b + c over W-bit operands with a 2W-bit result.
- Iterative shift-add datapath, one partial product per cycle, with valid/ready handshakes on input and output.
- Runtime-selectable exact or approximate mode. Approximate mode drops all partial-product bits below column TRUNC.
- Runs an exact shadow accumulator in parallel and reports the error against a threshold ET, so error-bounded approximations can be checked in-system.

---
 rtl/madd_seq_approx_pkg.sv | 23 ++
 rtl/madd_seq_approx_if.sv | 27 ++
 rtl/madd_seq_approx_pp_step.sv | 20 ++
 rtl/madd_seq_approx.sv | 110 +++++++++++
 tb/tb_madd_seq_approx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/madd_seq_approx_pkg.sv
// Shared types and helpers for the sequential approximate multiply-add.
package madd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned RW_MAX = 64;

  // Clears columns below trunc inside a 2w-bit result; bits above 2w are zero.
  function automatic logic [RW_MAX-1:0] trunc_mask(input int unsigned w,
                                                   input int unsigned trunc);
    logic [RW_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < RW_MAX; i++) begin
      m[i] = (i < 2 * w) && (i >= trunc);
    end
    return m;
  endfunction

endpackage

// File: rtl/madd_seq_approx_if.sv
// Operand/result handshake bundle for madd_seq_approx.
interface madd_seq_approx_if #(
  parameter int unsigned W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [W-1:0]   in_c;
  logic           in_approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_sum;
  logic [2*W-1:0] out_err;
  logic           out_exceed;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, in_c, in_approx, out_ready,
    input  in_ready, out_valid, out_sum, out_err, out_exceed, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_approx, out_ready,
    output in_ready, out_valid, out_sum, out_err, out_exceed, busy
  );
endinterface

// File: rtl/madd_seq_approx_pp_step.sv
// One shift-add step: exact and masked partial-product addends for column idx.
module madd_pp_step #(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = $clog2(W)
) (
  input  logic [W-1:0]   i_a,
  input  logic [IW-1:0]  i_idx,
  input  logic           i_bit,
  input  logic [2*W-1:0] i_mask,
  output logic [2*W-1:0] o_add_x,
  output logic [2*W-1:0] o_add_a
);
  logic [2*W-1:0] w_shift;

  always_comb begin
    w_shift = {{W{1'b0}}, i_a} << i_idx;
    o_add_x = i_bit ? w_shift : '0;
    o_add_a = o_add_x & i_mask;
  end
endmodule

// File: rtl/madd_seq_approx.sv
// Iterative a*b+c with optional column truncation and an exact shadow
// accumulator that reports the approximation error against ET.
module madd_seq_approx
  import madd_seq_pkg::*;
#(
  parameter int unsigned W          = 4,
  parameter int unsigned TRUNC      = 2,
  parameter int unsigned ET         = 2,
  parameter int unsigned EARLY_EXIT = 0
) (
  input logic               clk,
  input logic               rst,
  madd_seq_approx_if.slave  bus
);
  localparam int unsigned RW = 2 * W;
  localparam int unsigned IW = $clog2(W);
  localparam logic [RW-1:0] MASK = RW'(trunc_mask(W, TRUNC));

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_bsh;
  logic            r_approx;
  logic [IW-1:0]   r_idx;
  logic [RW-1:0]   r_acc_x;
  logic [RW-1:0]   r_acc_a;
  logic [RW-1:0]   r_sum;
  logic [RW-1:0]   r_err;
  logic            r_exceed;

  logic [RW-1:0]   w_mask;
  logic [RW-1:0]   w_add_x;
  logic [RW-1:0]   w_add_a;
  logic [RW-1:0]   w_nx_x;
  logic [RW-1:0]   w_nx_a;
  logic [RW-1:0]   w_nx_err;
  logic            w_last;

  madd_pp_step #(.W(W), .IW(IW)) u_step (
    .i_a     (r_a),
    .i_idx   (r_idx),
    .i_bit   (r_bsh[0]),
    .i_mask  (w_mask),
    .o_add_x (w_add_x),
    .o_add_a (w_add_a)
  );

  always_comb begin
    w_mask   = r_approx ? MASK : '1;
    w_nx_x   = r_acc_x + w_add_x;
    w_nx_a   = r_acc_a + w_add_a;
    w_nx_err = w_nx_x - w_nx_a;
    // Early exit looks at the multiplier bits still to come after this step.
    w_last   = (r_idx == IW'(W - 1)) ||
               ((EARLY_EXIT != 0) && ((r_bsh >> 1) == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_bsh    <= '0;
      r_approx <= 1'b0;
      r_idx    <= '0;
      r_acc_x  <= '0;
      r_acc_a  <= '0;
      r_sum    <= '0;
      r_err    <= '0;
      r_exceed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.in_a;
            r_bsh    <= bus.in_b;
            r_approx <= bus.in_approx;
            r_acc_x  <= {{W{1'b0}}, bus.in_c};
            r_acc_a  <= {{W{1'b0}}, bus.in_c};
            r_idx    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_acc_x <= w_nx_x;
          r_acc_a <= w_nx_a;
          r_bsh   <= r_bsh >> 1;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_sum    <= w_nx_a;
            r_err    <= w_nx_err;
            r_exceed <= (w_nx_err > RW'(ET));
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.out_sum    = r_sum;
  assign bus.out_err    = r_err;
  assign bus.out_exceed = r_exceed;
endmodule

// File: tb/tb_madd_seq_approx.sv
// Scoreboard bench: two instances (EARLY_EXIT 0 and 1) share one driver.
module tb_madd_seq_approx;
  localparam int unsigned W     = 4;
  localparam int unsigned TRUNC = 2;
  localparam int unsigned ET    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  madd_seq_approx_if #(.W(W)) bus0 ();
  madd_seq_approx_if #(.W(W)) bus1 ();

  madd_seq_approx #(.W(W), .TRUNC(TRUNC), .ET(ET), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  madd_seq_approx #(.W(W), .TRUNC(TRUNC), .ET(ET), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  logic       sel = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_approx = 1'b0;
  logic       d_ordy = 1'b1;
  logic [3:0] d_a = '0, d_b = '0, d_c = '0;
  int         rmode = 0;

  assign bus0.in_valid  = d_valid && !sel;
  assign bus1.in_valid  = d_valid && sel;
  assign bus0.out_ready = d_ordy && !sel;
  assign bus1.out_ready = d_ordy && sel;
  assign bus0.in_a = d_a;  assign bus1.in_a = d_a;
  assign bus0.in_b = d_b;  assign bus1.in_b = d_b;
  assign bus0.in_c = d_c;  assign bus1.in_c = d_c;
  assign bus0.in_approx = d_approx;
  assign bus1.in_approx = d_approx;

  logic       m_in_ready, m_out_valid, m_exc, m_busy;
  logic [7:0] m_sum, m_err;
  assign m_in_ready  = sel ? bus1.in_ready   : bus0.in_ready;
  assign m_out_valid = sel ? bus1.out_valid  : bus0.out_valid;
  assign m_exc       = sel ? bus1.out_exceed : bus0.out_exceed;
  assign m_busy      = sel ? bus1.busy       : bus0.busy;
  assign m_sum       = sel ? bus1.out_sum    : bus0.out_sum;
  assign m_err       = sel ? bus1.out_err    : bus0.out_err;

  typedef struct {
    logic [7:0] sum;
    logic [7:0] err;
    logic       exc;
    int         lat;
    int         t0;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  function automatic exp_t mk(input int s, input int e, input int x, input int l);
    exp_t r;
    r.sum = 8'(s); r.err = 8'(e); r.exc = x[0]; r.lat = l; r.t0 = 0;
    return r;
  endfunction

  // Reference: exact a*b+c; approximate drops each partial product's low TRUNC columns.
  function automatic exp_t model(input int a, input int b, input int c,
                                 input bit ap, input bit ee);
    int ex, apx, msb, pp;
    ex  = a * b + c;
    apx = c;
    msb = -1;
    for (int i = 0; i < int'(W); i++) begin
      if (((b >> i) & 1) == 1) begin
        msb = i;
        pp  = a * (1 << i);
        apx += ap ? (pp / (1 << TRUNC)) * (1 << TRUNC) : pp;
      end
    end
    return mk(apx, ex - apx, ((ex - apx) > int'(ET)) ? 1 : 0,
              ee ? ((msb + 1 > 1) ? msb + 1 : 1) : int'(W));
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send_core(input int a, input int b, input int c, input bit ap,
                           input exp_t e, output int waited);
    int n = 0;
    d_a = 4'(a); d_b = 4'(b); d_c = 4'(c); d_approx = ap; d_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!m_in_ready) begin
      d_valid = 1'b0;
      timeout("accept_wait");
      return;
    end
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    e.t0 = cyc;
    q.push_back(e);
  endtask

  task automatic send(input int a, input int b, input int c, input bit ap);
    int w;
    send_core(a, b, c, ap, model(a, b, c, ap, sel), w);
  endtask

  task automatic send_e(input int a, input int b, input int c, input bit ap, input exp_t e);
    int w;
    send_core(a, b, c, ap, e, w);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) d_ordy = 1'b1;
      else if (rmode == 1) d_ordy = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: first cycle of out_valid pops and compares; later cycles check hold.
  initial begin
    bit         seen = 1'b0;
    exp_t       h;
    logic [7:0] hs, he;
    logic       hx;
    forever begin
      @(negedge clk);
      if (!m_out_valid) begin
        seen = 1'b0;
      end else if (!seen) begin
        if (q.size() == 0) begin
          timeout("unexpected_output");
        end else begin
          h = q.pop_front();
          chk("out_sum", m_sum, h.sum);
          chk("out_err", m_err, h.err);
          chk("out_exceed", m_exc, h.exc);
          chk("latency", cyc - h.t0, h.lat);
        end
        hs = m_sum; he = m_err; hx = m_exc;
        seen = 1'b1;
      end else begin
        chk("hold_sum", m_sum, hs);
        chk("hold_err", m_err, he);
        chk("hold_exceed", m_exc, hx);
      end
    end
  end

  initial begin
    #5ms;
    timeout("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, m_in_ready, 1);
    chk({tag, "_out_valid"}, m_out_valid, 0);
    chk({tag, "_out_sum"}, m_sum, 0);
    chk({tag, "_out_err"}, m_err, 0);
    chk({tag, "_out_exceed"}, m_exc, 0);
    chk({tag, "_busy"}, m_busy, 0);
  endtask

  initial begin
    int w, n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors with hand-derived results.
    send_e(15, 15, 15, 1, mk(235, 5, 1, 4));
    send_e(4, 3, 2, 1, mk(14, 0, 0, 4));
    send_e(3, 5, 1, 1, mk(13, 3, 1, 4));
    send_e(15, 15, 15, 0, mk(240, 0, 0, 4));
    drain();

    for (int ap = 0; ap < 2; ap++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          for (int c = 0; c < 16; c++)
            send(a, b, c, ap[0]);
    drain();

    // Backpressure: result held, inputs ignored while DONE.
    rmode = 2;
    d_ordy = 1'b0;
    send(7, 9, 5, 1);
    n = 0;
    while (!m_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_out_valid) timeout("bp_valid_wait");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      d_valid = 1'b1;
      d_a = 4'($urandom); d_b = 4'($urandom); d_c = 4'($urandom);
      @(negedge clk);
      chk("bp_in_ready", m_in_ready, 0);
      chk("bp_busy", m_busy, 1);
    end
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_busy", m_busy, 0);
    chk("post_hs_out_valid", m_out_valid, 0);
    chk("post_hs_in_ready", m_in_ready, 1);
    send_core(2, 13, 11, 0, model(2, 13, 11, 0, sel), w);
    chk("b2b_wait", w, 0);
    rmode = 0;
    drain();

    // Reset during the second BUSY cycle discards the operation.
    send(9, 11, 6, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    chk_idle_zero("midrst");
    send(13, 6, 9, 1);
    drain();

    // Random traffic with backpressure on both instances.
    rmode = 1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      if (s == 1) begin
        send_e(9, 1, 3, 0, mk(12, 0, 0, 1));
        send_e(5, 0, 7, 1, mk(7, 0, 0, 1));
        send_e(3, 8, 2, 0, mk(26, 0, 0, 4));
      end
      for (int i = 0; i < 300; i++)
        send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             1'($urandom_range(0, 1)));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
